// File: rtl/tdc_measure_ctrl.sv
// tdc_measure_ctrl: one start/stop coarse interval measurement with valid/ready result
module tdc_measure_ctrl #(
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             abort,
  input  logic             start_level,
  input  logic             stop_level,
  input  logic             result_ready,
  output logic             result_valid,
  output logic [CNT_W-1:0] result_data,
  output logic             result_timeout,
  output logic             busy,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE, ARMED, RUNNING, DONE} state_t;
  state_t st;
  logic [CNT_W-1:0] count;
  logic start_prev, stop_prev;
  logic start_rise, stop_rise;
  assign start_rise = start_level & ~start_prev;
  assign stop_rise = stop_level & ~stop_prev;
  assign state = st;
  assign busy = (st == ARMED) || (st == RUNNING);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= IDLE;
      count <= '0;
      start_prev <= 1'b0;
      stop_prev <= 1'b0;
      result_valid <= 1'b0;
      result_data <= '0;
      result_timeout <= 1'b0;
    end else begin
      start_prev <= start_level;
      stop_prev <= stop_level;
      if (abort) begin
        st <= IDLE;
        count <= '0;
        result_valid <= 1'b0;
        result_data <= '0;
        result_timeout <= 1'b0;
      end else
        case (st)
          IDLE: if (arm) st <= ARMED;
          ARMED:
            if (start_rise) begin
              st <= RUNNING;
              count <= CNT_W'(1);
            end
          RUNNING:
            if (stop_rise) begin
              st <= DONE;
              result_data <= count;
              result_timeout <= 1'b0;
              result_valid <= 1'b1;
            end else if (count == TIMEOUT) begin
              st <= DONE;
              result_data <= TIMEOUT;
              result_timeout <= 1'b1;
              result_valid <= 1'b1;
            end else count <= count + 1'b1;
          DONE:
            if (result_ready) begin
              result_valid <= 1'b0;
              st <= arm ? ARMED : IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// tb_tdc_measure_ctrl: randomized measurements against an interval model with a result scoreboard
module tb_tdc_measure_ctrl;
  localparam int W = 16, TO = 20;
  logic clk = 0, reset = 0, arm = 0, abort = 0, start_level = 0, stop_level = 0, result_ready = 0;
  logic result_valid, result_timeout, busy;
  logic [W-1:0] result_data;
  logic [1:0] state;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {int data; bit to; int at;} exp_t;
  exp_t q[$];
  exp_t cur;
  bit pv = 0;

  tdc_measure_ctrl #(.CNT_W(W), .TIMEOUT(16'd20)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort),
    .start_level(start_level), .stop_level(stop_level), .result_ready(result_ready),
    .result_valid(result_valid), .result_data(result_data), .result_timeout(result_timeout),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: a new result is the first cycle result_valid is seen high
  always @(negedge clk) begin
    if (!reset) pv = 0;
    else begin
      if (result_valid && !pv) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got data %0d, none was due", result_data);
        end else begin
          cur = q.pop_front();
          chk("data", result_data, cur.data);
          chk("timeout", result_timeout, cur.to);
          chk("valid_cycle", cyc, cur.at);
        end
      end else if (result_valid) begin
        chk("hold_data", result_data, cur.data);
        chk("hold_timeout", result_timeout, cur.to);
      end
      pv = result_valid;
    end
  end

  initial begin
    int k, mode, e, lim, a, w, exp_data;
    bit armed, raise;
    armed = 0;
    #12;
    chk("rst_valid", result_valid, 0);
    chk("rst_data", result_data, 0);
    chk("rst_timeout", result_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state, 0);
    @(negedge clk) reset = 1;
    tick();
    for (int m = 0; m < 40; m++) begin
      if (!armed) begin
        arm = 1;
        tick();
        arm = 0;
      end
      chk("armed_state", state, 1);
      chk("armed_busy", busy, 1);
      repeat ($urandom_range(0, 3)) tick();
      mode = $urandom_range(0, 3);
      k = $urandom_range(2, TO + 4);
      a = $urandom_range(1, TO - 1);
      if (m == 0) begin mode = 0; k = 5; end
      if (m == 1) begin mode = 0; k = TO + 1; end
      if (m == 2) begin mode = 0; k = TO; end
      if (m == 3) begin mode = 1; k = 7; end
      if (m == 4) begin mode = 3; a = 4; end
      if (mode == 2) begin
        stop_level = 1;
        tick();
      end
      start_level = 1;
      if (mode == 1) stop_level = 1;
      e = cyc + 1;
      raise = (mode <= 1) && (k <= TO);
      lim = (mode == 3) ? a : (raise ? k : TO);
      if (mode != 3) begin
        exp_data = raise ? k : TO;
        q.push_back('{exp_data, !raise, e + exp_data});
      end
      tick();
      chk("running_state", state, 2);
      if (mode == 1) stop_level = 0;
      while (cyc < e + lim - 1) begin
        start_level = 1'($urandom_range(0, 1));
        result_ready = 1'($urandom_range(0, 1));
        tick();
      end
      result_ready = 0;
      if (raise) stop_level = 1;
      if (mode == 3) abort = 1;
      tick();
      if (mode == 3) begin
        abort = 0;
        chk("abort_state", state, 0);
        chk("abort_valid", result_valid, 0);
        chk("abort_data", result_data, 0);
        chk("abort_busy", busy, 0);
        start_level = 0;
        stop_level = 0;
        armed = 0;
        tick();
        continue;
      end
      w = 0;
      while (!result_valid && w < TO + 5) begin
        tick();
        w++;
      end
      if (!result_valid) begin
        total++;
        bad++;
        $display("FAIL result_wait: got no result_valid, expected one within %0d cycles", TO + 5);
      end
      repeat ($urandom_range(0, 5)) begin
        stop_level = ~stop_level;
        start_level = ~start_level;
        tick();
      end
      result_ready = 1;
      armed = 1'($urandom_range(0, 1));
      arm = armed;
      start_level = 0;
      stop_level = 0;
      tick();
      result_ready = 0;
      arm = 0;
      chk("post_state", state, armed ? 1 : 0);
      chk("post_valid", result_valid, 0);
      chk("retain_data", result_data, exp_data);
    end
    if (!armed) begin
      arm = 1;
      tick();
      arm = 0;
    end
    start_level = 1;
    e = cyc + 1;
    q.push_back('{3, 0, e + 3});
    tick();
    while (cyc < e + 2) tick();
    stop_level = 1;
    w = 0;
    while (!result_valid && w < TO + 5) begin
      tick();
      w++;
    end
    chk("final_valid", result_valid, 1);
    tick();
    #2 reset = 0;
    #1;
    chk("rst2_valid", result_valid, 0);
    chk("rst2_data", result_data, 0);
    chk("rst2_timeout", result_timeout, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_state", state, 0);
    chk("queue_empty", q.size(), 0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
